alu_pipe: RTL



---
 rtl/alu_pipe.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: registered ALU with valid/ready on both sides and result flags.
// Single-cycle ops load the output registers on the accept edge. MUL (op 14)
// is a shift-and-add multiply, one bit per cycle, present only when
// ALU_PIPE_MUL_EN is defined. Without it, op 14 is a single-cycle illegal op
// that returns result 0.
module alu_pipe #(
    parameter int DATA_WIDTH = 16,
    localparam int SHIFT_W = $clog2(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [3:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] data1,
    input  logic [DATA_WIDTH-1:0] data2,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] alu_result,
    output logic                  compare,
    output logic                  zero,
    output logic                  carry,
    output logic                  overflow,
    output logic                  illegal
);

    localparam logic [3:0] OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_LNOT = 4'd2,
                           OP_AND  = 4'd3,  OP_OR   = 4'd4,  OP_NAND = 4'd5,
                           OP_NOR  = 4'd6,  OP_PASS1 = 4'd7, OP_PASS2 = 4'd8,
                           OP_XOR  = 4'd9,  OP_SLL  = 4'd10, OP_SRL  = 4'd11,
                           OP_SRA  = 4'd12, OP_SLT  = 4'd13, OP_MUL  = 4'd14;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] result;
        logic                  compare;
        logic                  zero;
        logic                  carry;
        logic                  overflow;
        logic                  illegal;
    } alu_rsp_t;

    localparam int MSB = DATA_WIDTH - 1;

    logic [SHIFT_W-1:0]  shamt;
    logic [DATA_WIDTH:0] sum_w;
    logic [DATA_WIDTH:0] diff_w;
    alu_rsp_t            sc_rsp;
    alu_rsp_t            mul_rsp;
    alu_rsp_t            rsp_q, rsp_d;
    logic                out_valid_q, out_valid_d;
    logic                idle;
    logic                is_mul;
    logic                mul_load;
    logic                accept;

    assign shamt  = data2[SHIFT_W-1:0];
    assign sum_w  = {1'b0, data1} + {1'b0, data2};
    // Top bit of the widened difference is the unsigned borrow.
    assign diff_w = {1'b0, data1} - {1'b0, data2};

    // Single-cycle datapath: result and flags for the presented operands.
    always_comb begin
        sc_rsp = '0;
        case (alu_op)
            OP_ADD: begin
                sc_rsp.result   = sum_w[MSB:0];
                sc_rsp.carry    = sum_w[DATA_WIDTH];
                sc_rsp.overflow = (data1[MSB] == data2[MSB]) && (sum_w[MSB] != data1[MSB]);
            end
            OP_SUB: begin
                sc_rsp.result   = diff_w[MSB:0];
                sc_rsp.carry    = diff_w[DATA_WIDTH];
                sc_rsp.overflow = (data1[MSB] != data2[MSB]) && (diff_w[MSB] != data1[MSB]);
            end
            // Logical (not bitwise) NOT, kept for software compatibility.
            OP_LNOT:  sc_rsp.result = {{(DATA_WIDTH-1){1'b0}}, (data1 == '0)};
            OP_AND:   sc_rsp.result = data1 & data2;
            OP_OR:    sc_rsp.result = data1 | data2;
            OP_NAND:  sc_rsp.result = ~(data1 & data2);
            OP_NOR:   sc_rsp.result = ~(data1 | data2);
            OP_PASS1: sc_rsp.result = data1;
            OP_PASS2: sc_rsp.result = data2;
            OP_XOR:   sc_rsp.result = data1 ^ data2;
            OP_SLL:   sc_rsp.result = data1 << shamt;
            OP_SRL:   sc_rsp.result = data1 >> shamt;
            OP_SRA:   sc_rsp.result = $signed(data1) >>> shamt;
            OP_SLT:   sc_rsp.result = {{(DATA_WIDTH-1){1'b0}}, ($signed(data1) < $signed(data2))};
`ifdef ALU_PIPE_MUL_EN
            // Result comes from the multiply FSM, not from this path.
            OP_MUL:   sc_rsp.illegal = 1'b0;
`else
            OP_MUL:   sc_rsp.illegal = 1'b1;
`endif
            default:  sc_rsp.illegal = 1'b1;
        endcase
        sc_rsp.compare = (data1 == data2);
        sc_rsp.zero    = (sc_rsp.result == '0);
    end

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] mcand_q, mcand_d;
    logic [DATA_WIDTH-1:0] mplier_q, mplier_d;
    logic [DATA_WIDTH-1:0] acc_q, acc_d;
    logic [SHIFT_W-1:0]    cnt_q, cnt_d;
    logic                  mcmp_q, mcmp_d;

    assign idle     = (state_q == S_IDLE);
    assign is_mul   = (alu_op == OP_MUL);
    assign mul_load = (state_q == S_DONE) && (!out_valid_q || out_ready);

    always_comb begin
        mul_rsp         = '0;
        mul_rsp.result  = acc_q;
        mul_rsp.compare = mcmp_q;
        mul_rsp.zero    = (acc_q == '0);
    end

    // Multiply FSM: one multiplier bit per cycle, then wait for the output slot.
    always_comb begin
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        mcmp_d   = mcmp_q;
        case (state_q)
            S_IDLE: begin
                if (accept && is_mul) begin
                    state_d  = S_MUL;
                    mcand_d  = data1;
                    mplier_d = data2;
                    mcmp_d   = (data1 == data2);
                    acc_d    = '0;
                    cnt_d    = '0;
                end
            end
            S_MUL: begin
                if (mplier_q[0]) acc_d = acc_q + mcand_q;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + SHIFT_W'(1);
                if (cnt_q == SHIFT_W'(DATA_WIDTH - 1)) state_d = S_DONE;
            end
            S_DONE: begin
                if (mul_load) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Multiply state registers; reset aborts any multiply in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            mcmp_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            mcmp_q   <= mcmp_d;
        end
    end
`else
    assign idle     = 1'b1;
    assign is_mul   = 1'b0;
    assign mul_load = 1'b0;
    assign mul_rsp  = '0;
`endif

    // A full output slot can drain and refill in the same cycle.
    assign in_ready = idle && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Output slot: load a new result, drop a consumed one, otherwise hold.
    always_comb begin
        rsp_d       = rsp_q;
        out_valid_d = out_valid_q;
        if (out_ready) out_valid_d = 1'b0;
        if (accept && !is_mul) begin
            rsp_d       = sc_rsp;
            out_valid_d = 1'b1;
        end else if (mul_load) begin
            rsp_d       = mul_rsp;
            out_valid_d = 1'b1;
        end
    end

    // Output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_q       <= '0;
            out_valid_q <= 1'b0;
        end else begin
            rsp_q       <= rsp_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign out_valid  = out_valid_q;
    assign alu_result = rsp_q.result;
    assign compare    = rsp_q.compare;
    assign zero       = rsp_q.zero;
    assign carry      = rsp_q.carry;
    assign overflow   = rsp_q.overflow;
    assign illegal    = rsp_q.illegal;

endmodule
